lyra2_slot_scheduler: RTL
=========================

Name: lyra2_slot_scheduler

Overview:
- Controller for an interleaved, fixed-latency Lyra2 round core. The core has PIPELINE_STAGES stages, and each pipeline slot carries one independent hash job.
- Issues new jobs into free slots and feeds each slot's result back for ROUNDS_PER_JOB rounds.
- Collects finished results into an output FIFO with valid/ready handshake.
- Generalises the fixed 8-stage / 68-round / 256-bit configuration to arbitrary stages, rounds, width and job tagging. Adds back-pressure handling.

Parameters:
- PIPELINE_STAGES, 8: core latency in cycles; also the number of interleaved slots (>=2).
- DATA_WIDTH, 256: job input and result width.
- ROUNDS_PER_JOB, 68: core passes per job; total compute time is ROUNDS_PER_JOB*PIPELINE_STAGES cycles.
- OUT_FIFO_DEPTH, 4: result FIFO entries (power of 2, >=2).
- ID_WIDTH, 4: job tag width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  job accepted this cycle when in_valid is also high
- in_data  in  DATA_WIDTH  job seed
- in_id  in  ID_WIDTH  job tag
- core_req_valid  out  1  request into the core this cycle
- core_req_first  out  1  request is round 0 of a new job
- core_req_bypass  out  1  core must pass data through unchanged
- core_req_data  out  DATA_WIDTH  core input
- core_rsp_valid  in  1  core output valid; returns exactly PIPELINE_STAGES cycles after the request
- core_rsp_data  in  DATA_WIDTH  core output
- out_valid  out  1  FIFO head valid
- out_ready  in  1  pop FIFO head
- out_data  out  DATA_WIDTH  result
- out_id  out  ID_WIDTH  result tag
- busy_slots  out  $clog2(PIPELINE_STAGES+1)  number of non-idle slots

Behaviour:
- Reset (async, rst=1):
  - slot pointer = 0; all slots IDLE; round counters = 0; FIFO empty.
  - All outputs are 0, including in_ready, core_req_* and out_valid.
- Slot pointer: free-running, increments every cycle, wraps PIPELINE_STAGES-1 -> 0. Only the slot under the pointer acts in a given cycle.
- Per-slot state:
  - IDLE / BUSY.
  - round counter, $clog2(ROUNDS_PER_JOB) bits.
  - stored ID.
- Per-cycle action for slot s at the pointer:
  - **BUSY, response arrives, round < ROUNDS_PER_JOB-1:**
    - issue core_req_valid=1, first=0, bypass=0, data=core_rsp_data.
    - round++.
  - **BUSY, response arrives, round == ROUNDS_PER_JOB-1, FIFO not full:**
    - push {core_rsp_data, id}; slot becomes IDLE.
    - In the same cycle the slot may accept a new job, per the IDLE rule below.
  - **Same final case, FIFO full:**
    - issue bypass=1, data=core_rsp_data; round is unchanged.
    - Retry on the next lap. No data is lost and no per-slot storage is needed.
  - **IDLE, or freed this cycle, with in_valid=1:**
    - in_ready=1; issue first=1, data=in_data.
    - slot becomes BUSY, round=0, id=in_id.
  - **Otherwise:** core_req_valid=0.
- in_ready is combinational: 1 iff the pointed slot is IDLE or is completing with FIFO not full.
- A core_rsp_valid arriving for an IDLE slot is ignored.
- Latency:
  - job accepted at cycle t; final response arrives at t+ROUNDS_PER_JOB*PIPELINE_STAGES.
  - out_valid rises at t+ROUNDS_PER_JOB*PIPELINE_STAGES+1 (544/545 at the defaults).
  - Each bypass lap adds PIPELINE_STAGES cycles.
- FIFO:
  - first-word registered at the head.
  - A push and a pop in the same cycle while full is not allowed: full is evaluated before the pop.
  - A push and a pop while empty passes the entry through with 1-cycle latency.
  - Jobs can complete out of order relative to acceptance; out_id identifies each result.
- busy_slots is a registered count that updates the cycle after the slot state changes.

Optional Feature:
- Macro: LYRA2_SCHED_FLUSH_EN.
- When defined:
  - adds input port flush (1 bit, synchronous).
  - On flush=1, at the next edge: all slots go IDLE, rounds = 0, and the FIFO is emptied.
  - During the flush cycle, in_ready=0 and core_req_valid=0.
  - In-flight core responses for the following PIPELINE_STAGES cycles are ignored because their slots are IDLE.
- When undefined: no flush port; the logic is absent.

Test Plan:
- **Reset mid-job:** assert rst 100 cycles after accepting a job -> all outputs 0 immediately; busy_slots=0; no output ever appears.
- **Single job (defaults), with a behavioural core model that XORs a round constant:** in_id=3 accepted at t -> out_valid at t+545 with out_id=3; data matches the reference model for 68 rounds.
- **Full load:** offer 8 jobs back-to-back, one per cycle -> all accepted; busy_slots=8; the 9th stalls (in_ready=0) until the first slot completes, then is accepted in that same completion cycle.
- **Back-pressure:** out_ready=0 with 8 jobs in flight -> 4 results fill the FIFO; the remaining slots issue bypass=1 each lap with round unchanged; releasing out_ready -> all 8 results drain, data intact.
- **Wrap and parameterisation:** PIPELINE_STAGES=3, ROUNDS_PER_JOB=2 -> results at t+7; pointer wraps 2->0 correctly.
- **Flush (LYRA2_SCHED_FLUSH_EN):** flush with 5 busy slots and 2 FIFO entries -> out_valid=0 and busy_slots=0 on the following cycle; late core responses do not create outputs.

Source files
------------

// File: rtl/lyra2_slot_scheduler.sv
// Slot scheduler for an interleaved fixed-latency Lyra2 round core, with a FWFT result FIFO.
// Optional synchronous flush port enabled by defining LYRA2_SCHED_FLUSH_EN.
module lyra2_slot_scheduler #(
    parameter int PIPELINE_STAGES = 8,
    parameter int DATA_WIDTH      = 256,
    parameter int ROUNDS_PER_JOB  = 68,
    parameter int OUT_FIFO_DEPTH  = 4,
    parameter int ID_WIDTH        = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
`ifdef LYRA2_SCHED_FLUSH_EN
    input  logic                                       flush,
`endif
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [DATA_WIDTH-1:0]                      in_data,
    input  logic [ID_WIDTH-1:0]                        in_id,
    output logic                                       core_req_valid,
    output logic                                       core_req_first,
    output logic                                       core_req_bypass,
    output logic [DATA_WIDTH-1:0]                      core_req_data,
    input  logic                                       core_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                      core_rsp_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [DATA_WIDTH-1:0]                      out_data,
    output logic [ID_WIDTH-1:0]                        out_id,
    output logic [$clog2(PIPELINE_STAGES+1)-1:0]       busy_slots
);

    localparam int PW = (PIPELINE_STAGES > 1) ? $clog2(PIPELINE_STAGES) : 1;
    localparam int RW = (ROUNDS_PER_JOB > 1) ? $clog2(ROUNDS_PER_JOB) : 1;
    localparam int FW = $clog2(OUT_FIFO_DEPTH);
    localparam int CW = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int BW = $clog2(PIPELINE_STAGES + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} slotState_t;

    slotState_t          r_state [PIPELINE_STAGES];
    logic [RW-1:0]       r_round [PIPELINE_STAGES];
    logic [ID_WIDTH-1:0] r_id    [PIPELINE_STAGES];
    logic [PW-1:0]       r_ptr;
    logic [BW-1:0]       r_busyCount;

    logic [DATA_WIDTH-1:0] r_fifoData [OUT_FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   r_fifoId   [OUT_FIFO_DEPTH];
    logic [FW-1:0]         r_rdPtr;
    logic [FW-1:0]         r_wrPtr;
    logic [CW-1:0]         r_count;

    logic w_flush, w_live, w_busy, w_rsp, w_last, w_full;
    logic w_cont, w_done, w_bypass, w_free, w_accept, w_push, w_pop;
    slotState_t          w_nextState;
    logic [RW-1:0]       w_nextRound;
    logic [ID_WIDTH-1:0] w_nextId;

`ifdef LYRA2_SCHED_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // A response for the pointed slot returns exactly one lap after its request.
    assign w_live   = ~rst & ~w_flush;
    assign w_busy   = (r_state[r_ptr] == BUSY);
    assign w_rsp    = w_busy & core_rsp_valid;
    assign w_last   = (r_round[r_ptr] == RW'(ROUNDS_PER_JOB - 1));
    assign w_full   = (r_count == CW'(OUT_FIFO_DEPTH));
    assign w_cont   = w_rsp & ~w_last;
    assign w_done   = w_rsp & w_last & ~w_full;
    assign w_bypass = w_rsp & w_last & w_full;
    assign w_free   = ~w_busy | w_done;
    assign in_ready = w_free & w_live;
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_done & ~w_flush;
    assign w_pop    = out_ready & (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_busyCount <= '0;
            for (int i = 0; i < PIPELINE_STAGES; i++) begin
                r_state[i] <= IDLE;
                r_round[i] <= '0;
                r_id[i]    <= '0;
            end
        end else begin
            r_ptr <= (r_ptr == PW'(PIPELINE_STAGES - 1)) ? '0 : r_ptr + PW'(1);
            if (w_flush) begin
                r_busyCount <= '0;
                for (int i = 0; i < PIPELINE_STAGES; i++) begin
                    r_state[i] <= IDLE;
                    r_round[i] <= '0;
                end
            end else begin
                r_state[r_ptr] <= w_nextState;
                r_round[r_ptr] <= w_nextRound;
                r_id[r_ptr]    <= w_nextId;
                if (!w_busy && w_nextState == BUSY)
                    r_busyCount <= r_busyCount + BW'(1);
                else if (w_busy && w_nextState == IDLE)
                    r_busyCount <= r_busyCount - BW'(1);
            end
        end
    end

    always_comb begin
        w_nextState = r_state[r_ptr];
        w_nextRound = r_round[r_ptr];
        w_nextId    = r_id[r_ptr];
        if (w_accept) begin
            w_nextState = BUSY;
            w_nextRound = '0;
            w_nextId    = in_id;
        end else if (w_done) begin
            w_nextState = IDLE;
            w_nextRound = '0;
        end else if (w_cont) begin
            w_nextRound = r_round[r_ptr] + RW'(1);
        end
    end

    always_comb begin
        core_req_valid  = 1'b0;
        core_req_first  = 1'b0;
        core_req_bypass = 1'b0;
        core_req_data   = '0;
        if (w_live) begin
            if (w_accept) begin
                core_req_valid = 1'b1;
                core_req_first = 1'b1;
                core_req_data  = in_data;
            end else if (w_cont || w_bypass) begin
                core_req_valid  = 1'b1;
                core_req_bypass = w_bypass;
                core_req_data   = core_rsp_data;
            end
        end
    end

    // Fullness is judged before any pop, so a completing slot never pushes into a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + FW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + FW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoData[r_wrPtr] <= core_rsp_data;
            r_fifoId[r_wrPtr]   <= r_id[r_ptr];
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_fifoData[r_rdPtr] : '0;
    assign out_id     = out_valid ? r_fifoId[r_rdPtr] : '0;
    assign busy_slots = r_busyCount;

endmodule
